// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the ARM-subset instruction encoder: operand kinds,
// data-processing commands and the decoded field bundle.
package instr_pkg;

  typedef enum logic [1:0] {
    KIND_DP  = 2'd0,
    KIND_MEM = 2'd1,
    KIND_BR  = 2'd2,
    KIND_ILL = 2'd3
  } kind_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    kind_e       kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        i;
    logic        s;
    logic        l;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [11:0] imm12;
    logic [23:0] imm24;
  } fields_t;

  // Compare-class commands only update flags: S forced high, Rd forced to zero.
  function automatic logic is_cmp_class(input logic [3:0] cmd);
    return (cmd == CMD_TST) || (cmd == CMD_TEQ) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

  function automatic logic is_dp_cmd(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_EOR) || (cmd == CMD_SUB) || (cmd == CMD_RSB) ||
           (cmd == CMD_ADD) || (cmd == CMD_ORR) || (cmd == CMD_MOV) || is_cmp_class(cmd);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshake of the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [3:0]  in_cond;
  logic [3:0]  in_cmd;
  logic        in_i;
  logic        in_s;
  logic        in_l;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [3:0]  in_rm;
  logic [11:0] in_imm12;
  logic [23:0] in_imm24;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_kind, in_cond, in_cmd, in_i, in_s, in_l,
    output in_rn, in_rd, in_rm, in_imm12, in_imm24, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  modport slave (
    input  in_valid, in_kind, in_cond, in_cmd, in_i, in_s, in_l,
    input  in_rn, in_rd, in_rm, in_imm12, in_imm24, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field-to-word packer; flags bundles that have no legal encoding.
module instr_pack
  import instr_pkg::*;
(
    input  fields_t     fields_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic        dp_s;
    logic [3:0]  dp_rn;
    logic [3:0]  dp_rd;
    logic [11:0] dp_op2;

    always_comb begin
        dp_s   = fields_i.s | is_cmp_class(fields_i.cmd);
        dp_rd  = is_cmp_class(fields_i.cmd) ? 4'h0 : fields_i.rd;
        dp_rn  = (fields_i.cmd == CMD_MOV) ? 4'h0 : fields_i.rn;
        dp_op2 = fields_i.i ? fields_i.imm12 : {8'h00, fields_i.rm};
    end

    always_comb begin
        word_o    = '0;
        illegal_o = (fields_i.cond == COND_NV);
        case (fields_i.kind)
            KIND_DP: begin
                if (!is_dp_cmd(fields_i.cmd)) illegal_o = 1'b1;
                word_o = {fields_i.cond, 2'b00, fields_i.i, fields_i.cmd, dp_s,
                          dp_rn, dp_rd, dp_op2};
            end
            // Immediate offset, pre-indexed, add, word, no writeback.
            KIND_MEM: word_o = {fields_i.cond, 2'b01, 5'b01100, fields_i.l,
                                fields_i.rn, fields_i.rd, fields_i.imm12};
            KIND_BR:  word_o = {fields_i.cond, 4'b1010, fields_i.imm24};
            default:  illegal_o = 1'b1;
        endcase
        if (illegal_o) word_o = '0;
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: valid/ready field intake, one-deep output register,
// byte-address generation and saturating count of rejected bundles.
module instr_encoder
  import instr_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned ErrW     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    instr_encoder_if.slave   bus,
    output logic [ErrW-1:0]  err_count_o,
    output logic             err_last_o
);

    fields_t     fields;
    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic        drain;

    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [31:0]     out_addr_q,  out_addr_d;
    logic [ErrW-1:0] err_count_q, err_count_d;
    logic            err_last_q,  err_last_d;

    always_comb begin
        fields.kind  = kind_e'(bus.in_kind);
        fields.cond  = bus.in_cond;
        fields.cmd   = bus.in_cmd;
        fields.i     = bus.in_i;
        fields.s     = bus.in_s;
        fields.l     = bus.in_l;
        fields.rn    = bus.in_rn;
        fields.rd    = bus.in_rd;
        fields.rm    = bus.in_rm;
        fields.imm12 = bus.in_imm12;
        fields.imm24 = bus.in_imm24;
    end

    instr_pack u_pack (
        .fields_i  (fields),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign bus.in_ready = rst_ni & ~start_i & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign drain        = out_valid_q & bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        err_count_d = err_count_q;
        err_last_d  = err_last_q;
        if (start_i) begin
            out_valid_d = 1'b0;
            out_addr_d  = BaseAddr;
            err_count_d = '0;
            err_last_d  = 1'b0;
        end else begin
            if (drain) begin
                out_valid_d = 1'b0;
                out_addr_d  = out_addr_q + 32'd4;
            end
            // Rejects leave the output stage alone; only the error state moves.
            if (accept) begin
                if (illegal) begin
                    if (err_count_q != '1) err_count_d = err_count_q + ErrW'(1);
                    err_last_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_instr_d = word;
                    err_last_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BaseAddr;
            err_count_q <= '0;
            err_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_count_q <= err_count_d;
            err_last_q  <= err_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign err_count_o   = err_count_q;
    assign err_last_o    = err_last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed bundles push {addr, word},
// a negedge monitor pops and compares on every output transfer.
module tb_instr_encoder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] err_count;
    logic       err_last;

    instr_encoder_if bus ();

    instr_encoder #(
        .BaseAddr (32'h0000_0000),
        .ErrW     (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .bus         (bus.slave),
        .err_count_o (err_count),
        .err_last_o  (err_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] addr_model = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %08h@%08h expected none",
                         bus.out_instr, bus.out_addr);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("out_addr", bus.out_addr, e[63:32]);
                check("out_instr", bus.out_instr, e[31:0]);
            end
        end
    end

    task automatic send(input logic [1:0] kind, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic i, input logic s, input logic l,
                        input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                        input logic [11:0] imm12, input logic [23:0] imm24,
                        input logic [31:0] exp, input logic legal);
        int n;
        bus.in_kind  = kind;  bus.in_cond  = cond;  bus.in_cmd = cmd;
        bus.in_i     = i;     bus.in_s     = s;     bus.in_l   = l;
        bus.in_rn    = rn;    bus.in_rd    = rd;    bus.in_rm  = rm;
        bus.in_imm12 = imm12; bus.in_imm24 = imm24;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 30) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else if (legal) begin
            sb_q.push_back({addr_model, exp});
            addr_model = addr_model + 32'd4;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_kind = 2'd0; bus.in_cond = 4'h0; bus.in_cmd = 4'h0;
        bus.in_i = 1'b0; bus.in_s = 1'b0; bus.in_l = 1'b0;
        bus.in_rn = 4'h0; bus.in_rd = 4'h0; bus.in_rm = 4'h0;
        bus.in_imm12 = 12'h0; bus.in_imm24 = 24'h0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_addr", bus.out_addr, 32'h0);
        check("rst_err_count", {24'b0, err_count}, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD R1,R2,#5 / CMP R3,R4 / MOV R5,#1
        send(2'd0, 4'hE, 4'b0100, 1, 0, 0, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0, 32'hE2821005, 1);
        send(2'd0, 4'hE, 4'b1010, 0, 0, 0, 4'd3, 4'd7, 4'd4, 12'h000, 24'h0, 32'hE1530004, 1);
        send(2'd0, 4'hE, 4'b1101, 1, 0, 0, 4'd9, 4'd5, 4'd0, 12'h001, 24'h0, 32'hE3A05001, 1);

        // Rejects: unsupported cmd, then illegal kind
        send(2'd0, 4'hE, 4'b0101, 0, 0, 0, 4'd1, 4'd1, 4'd1, 12'h000, 24'h0, 32'h0, 0);
        check("rej_no_valid", {31'b0, bus.out_valid}, 32'h0);
        send(2'd3, 4'hE, 4'b0000, 0, 0, 0, 4'd1, 4'd1, 4'd1, 12'h000, 24'h0, 32'h0, 0);
        check("rej_no_valid2", {31'b0, bus.out_valid}, 32'h0);
        check("rej_err_count", {24'b0, err_count}, 32'd2);
        check("rej_err_last", {31'b0, err_last}, 32'd1);

        // LDR R0,[R1,#8] takes the next unused address
        send(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 32'hE5910008, 1);
        check("legal_clears_last", {31'b0, err_last}, 32'd0);
        drain_wait();

        // Start while a word is held at 0x10
        bus.out_ready = 1'b0;
        send(2'd1, 4'hE, 4'h0, 0, 0, 0, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 32'hE5810008, 1);
        check("held_addr", bus.out_addr, 32'h10);
        check("held_valid", {31'b0, bus.out_valid}, 32'h1);
        start = 1'b1;
        @(negedge clk);
        check("start_in_ready", {31'b0, bus.in_ready}, 32'h0);
        @(posedge clk);
        #1 start = 1'b0;
        sb_q.delete();
        addr_model = 32'h0;
        check("start_valid", {31'b0, bus.out_valid}, 32'h0);
        check("start_addr", bus.out_addr, 32'h0);
        check("start_err", {24'b0, err_count}, 32'h0);
        bus.out_ready = 1'b1;

        // LDR / STR / B at 0,4,8
        send(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 32'hE5910008, 1);
        send(2'd1, 4'hE, 4'h0, 0, 0, 0, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 32'hE5810008, 1);
        send(2'd2, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 32'hEAFFFFFE, 1);
        drain_wait();

        // Backpressure: ADD held at 0xC for 5 cycles while CMP waits
        bus.out_ready = 1'b0;
        send(2'd0, 4'hE, 4'b0100, 1, 0, 0, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0, 32'hE2821005, 1);
        fork
            send(2'd0, 4'hE, 4'b1010, 0, 0, 0, 4'd3, 4'd7, 4'd4, 12'h000, 24'h0, 32'hE1530004, 1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
                    check("stall_instr", bus.out_instr, 32'hE2821005);
                    check("stall_addr", bus.out_addr, 32'hC);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        send(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0, 32'hE5910008, 1);
        drain_wait();

        // Reset mid-stream with a held word and nonzero error count
        bus.out_ready = 1'b0;
        send(2'd0, 4'hF, 4'b0100, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h000, 24'h0, 32'h0, 0);
        send(2'd0, 4'hE, 4'b1101, 1, 0, 0, 4'd0, 4'd5, 4'd0, 12'h001, 24'h0, 32'hE3A05001, 1);
        check("pre_rst_err", {24'b0, err_count}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        addr_model = 32'h0;
        check("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("mid_rst_instr", bus.out_instr, 32'h0);
        check("mid_rst_addr", bus.out_addr, 32'h0);
        check("mid_rst_err", {24'b0, err_count}, 32'h0);
        check("mid_rst_last", {31'b0, err_last}, 32'h0);
        check("mid_rst_ready", {31'b0, bus.in_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(2'd0, 4'hE, 4'b0100, 1, 0, 0, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0, 32'hE2821005, 1);
        drain_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
